// File: rtl/e_mdu.sv
`default_nettype none
// ============================================================================
//  Module   : e_mdu
//  Brief    : Execute-stage multi-cycle multiply/divide unit owning HI/LO.
//             Optional MADD/MADDU/MSUB/MSUBU accumulate ops: MDU_MADD_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module e_mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic        Start,
    input  logic [3:0]  Op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        Busy,
    output logic        Stall_MD,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    localparam logic [3:0] c_OP_MULT  = 4'd0;
    localparam logic [3:0] c_OP_MULTU = 4'd1;
    localparam logic [3:0] c_OP_DIV   = 4'd2;
    localparam logic [3:0] c_OP_DIVU  = 4'd3;
    localparam logic [3:0] c_OP_MTHI  = 4'd4;
    localparam logic [3:0] c_OP_MTLO  = 4'd5;
`ifdef MDU_MADD_EN
    localparam logic [3:0] c_OP_MADD  = 4'd6;
    localparam logic [3:0] c_OP_MADDU = 4'd7;
    localparam logic [3:0] c_OP_MSUB  = 4'd8;
    localparam logic [3:0] c_OP_MSUBU = 4'd9;
`endif
    localparam logic [4:0] c_MULT_CNT = 5'(MULT_CYCLES);
    localparam logic [4:0] c_DIV_CNT  = 5'(DIV_CYCLES);

    logic        r_busy;
    logic [4:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_is_arith;
    logic        w_is_div;
    logic        w_b_zero;
    logic        w_a_neg;
    logic        w_b_neg;
    logic [31:0] w_a_mag;
    logic [31:0] w_b_mag;
    logic [31:0] w_q_mag;
    logic [31:0] w_r_mag;
    logic [31:0] w_div_q;
    logic [31:0] w_div_r;
    logic [31:0] w_divu_q;
    logic [31:0] w_divu_r;
    logic [63:0] w_prod_s;
    logic [63:0] w_prod_u;
    logic [63:0] w_result;

    assign w_is_div = (Op == c_OP_DIV) | (Op == c_OP_DIVU);
`ifdef MDU_MADD_EN
    assign w_is_arith = (Op <= c_OP_DIVU) | ((Op >= c_OP_MADD) & (Op <= c_OP_MSUBU));
`else
    assign w_is_arith = (Op <= c_OP_DIVU);
`endif

    // Low 64 bits of an unsigned product of sign-extended operands equal the signed product.
    assign w_prod_s = {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
    assign w_prod_u = {32'd0, r_a} * {32'd0, r_b};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 with no overflow trap.
    assign w_b_zero = (r_b == 32'd0);
    assign w_a_neg  = r_a[31];
    assign w_b_neg  = r_b[31];
    assign w_a_mag  = w_a_neg ? (~r_a + 32'd1) : r_a;
    assign w_b_mag  = w_b_neg ? (~r_b + 32'd1) : r_b;
    assign w_q_mag  = w_b_zero ? 32'd0 : (w_a_mag / w_b_mag);
    assign w_r_mag  = w_b_zero ? 32'd0 : (w_a_mag % w_b_mag);
    assign w_div_q  = (w_a_neg ^ w_b_neg) ? (~w_q_mag + 32'd1) : w_q_mag;
    assign w_div_r  = w_a_neg ? (~w_r_mag + 32'd1) : w_r_mag;
    assign w_divu_q = w_b_zero ? 32'd0 : (r_a / r_b);
    assign w_divu_r = w_b_zero ? 32'd0 : (r_a % r_b);

    always_comb begin
        w_result = {r_hi, r_lo};
        case (r_op)
            c_OP_MULT:  w_result = w_prod_s;
            c_OP_MULTU: w_result = w_prod_u;
            c_OP_DIV:   w_result = w_b_zero ? {r_a, 32'hFFFF_FFFF} : {w_div_r, w_div_q};
            c_OP_DIVU:  w_result = w_b_zero ? {r_a, 32'hFFFF_FFFF} : {w_divu_r, w_divu_q};
`ifdef MDU_MADD_EN
            c_OP_MADD:  w_result = {r_hi, r_lo} + w_prod_s;
            c_OP_MADDU: w_result = {r_hi, r_lo} + w_prod_u;
            c_OP_MSUB:  w_result = {r_hi, r_lo} - w_prod_s;
            c_OP_MSUBU: w_result = {r_hi, r_lo} - w_prod_u;
`endif
            default:    w_result = {r_hi, r_lo};
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            r_busy <= 1'b0;
            r_cnt  <= 5'd0;
            r_op   <= 4'd0;
            r_a    <= 32'd0;
            r_b    <= 32'd0;
            r_hi   <= 32'd0;
            r_lo   <= 32'd0;
        end else if (r_busy) begin
            // Any Start seen while busy is dropped; decode holds it via Stall_MD.
            r_cnt <= r_cnt - 5'd1;
            if (r_cnt == 5'd1) begin
                r_busy <= 1'b0;
                r_hi   <= w_result[63:32];
                r_lo   <= w_result[31:0];
            end
        end else if (Start) begin
            if (w_is_arith) begin
                r_a    <= A;
                r_b    <= B;
                r_op   <= Op;
                r_busy <= 1'b1;
                r_cnt  <= w_is_div ? c_DIV_CNT : c_MULT_CNT;
            end else if (Op == c_OP_MTHI) begin
                r_hi <= A;
            end else if (Op == c_OP_MTLO) begin
                r_lo <= A;
            end
        end
    end

    assign Busy     = r_busy;
    assign Stall_MD = r_busy | Start;
    assign HI       = r_hi;
    assign LO       = r_lo;

endmodule
`default_nettype wire

// File: doc/e_mdu.md
Name: e_mdu

Overview:
- Multi-cycle multiply/divide unit in the Execute stage, alongside the ALU.
- Owns the HI/LO registers and executes mult/multu/div/divu/mthi/mtlo.
- HI/LO feed the E-stage result mux for mfhi/mflo, ahead of the E-to-M pipeline register.
- Exports a stall request that holds D/E while an operation is in flight.

Parameters:
- MULT_CYCLES, 5, cycles Busy stays high for multiply-class ops (legal range 1 to 31).
- DIV_CYCLES, 10, cycles Busy stays high for divide-class ops (legal range 1 to 31).

Ports:
- CLK  input  1  clock; all state changes on posedge.
- Reset  input  1  asynchronous, active-low reset.
- Start  input  1  E-stage instruction is an MDU op; sampled at posedge.
- Op  input  4  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MADD, 7 MADDU, 8 MSUB, 9 MSUBU; 10-15 no-op.
- A  input  32  rs operand (forwarded value).
- B  input  32  rt operand (forwarded value).
- Busy  output  1  operation in flight (registered).
- Stall_MD  output  1  combinational Busy | Start; D-stage stall request for MDU-dependent instructions.
- HI  output  32  HI register.
- LO  output  32  LO register.

Behaviour:
- Reset low, asynchronous: HI=0, LO=0, Busy=0, cycle counter=0, operand latches=0. Any op in progress is aborted and never writes.
- Start=1 and Busy=0 at posedge, Op in 0..3 (or 6..9 with the optional feature):
  - Latch A, B and Op.
  - Load counter with MULT_CYCLES or DIV_CYCLES; Busy=1 from that edge.
- Counting: counter decrements each posedge while Busy=1.
  - On the edge where counter goes 1 to 0: HI/LO written with the result, Busy cleared.
  - Result is visible and Busy=0 exactly N edges after the accepting edge (N = MULT_CYCLES or DIV_CYCLES).
- MTHI/MTLO with Busy=0: HI<=A or LO<=A at that posedge (1-cycle latency); Busy stays 0.
- Start=1 while Busy=1: ignored, all Op values. Decode must hold the instruction via Stall_MD; the block does not queue.
- Ops 10-15: no state change.
- MULT: {HI,LO} = signed 32x32 to 64 product.
- MULTU: {HI,LO} = unsigned 32x32 to 64 product.
- DIV: LO = quotient truncated toward zero; HI = remainder with the sign of the dividend.
- DIVU: LO = unsigned quotient; HI = unsigned remainder.
- Divide by zero: LO=32'hFFFFFFFF, HI=latched A, full DIV_CYCLES latency.
- DIV of 32'h80000000 by 32'hFFFFFFFF: LO=32'h80000000, HI=0.
- Result uses latched operands only; A/B changes during Busy have no effect.
- Reset low mid-operation: Busy drops immediately (asynchronously); HI/LO read 0.
- Stall_MD: asserted in the Start cycle and every Busy cycle. Deasserted in the cycle after the completing edge, so an mfhi/mflo then reads the new HI/LO.

Optional Feature:
- Macro: MDU_MADD_EN.
- Defined: Ops 6-9 use MULT_CYCLES latency. The product is computed from latched A/B at acceptance; {HI,LO} is read at the completing edge.
  - MADD: {HI,LO} += signed product.
  - MADDU: {HI,LO} += unsigned product.
  - MSUB: {HI,LO} -= signed product.
  - MSUBU: {HI,LO} -= unsigned product.
  - All arithmetic is 64-bit modulo 2^64.
- Not defined: Ops 6-9 are no-ops exactly like 10-15; no accumulator logic is synthesised.

Test Plan:
- Reset and MULT: hold Reset=0 then release; HI=LO=0, Busy=0. Start MULT A=32'hFFFFFFFE, B=3 -> Busy high for 5 cycles, then HI=32'hFFFFFFFF, LO=32'hFFFFFFFA; MULTU with the same operands -> HI=2, LO=32'hFFFFFFFA.
- Signed division: DIV A=-7 (32'hFFFFFFF9), B=2 -> after 10 cycles LO=32'hFFFFFFFD, HI=32'hFFFFFFFF. DIVU A=100, B=7 -> LO=14, HI=2.
- Divide by zero: DIV A=32'h12345678, B=0 -> LO=32'hFFFFFFFF, HI=32'h12345678 after 10 cycles.
- Overflow division: DIV A=32'h80000000, B=32'hFFFFFFFF -> LO=32'h80000000, HI=0.
- Busy interaction: start MULT 3x4, then on cycle 2 apply MTHI A=32'hDEAD and change A/B -> MTHI ignored, result HI=0, LO=12. Stall_MD high for cycles 0-5. MTLO A=9 on the next idle cycle -> LO=9 one edge later.
- Reset mid-operation: start DIVU 100/7, pull Reset low on cycle 4 -> Busy=0, HI=LO=0 immediately, no later write. With MDU_MADD_EN: MULTU 2x3, then MADD 4x5 -> LO=26, HI=0; MSUB 1x30 -> LO=32'hFFFFFFFC, HI=32'hFFFFFFFF.
